// File: rtl/ar_channel_arbiter_pkg.sv
// Shared types for the AR channel arbiter: FSM state encoding, AR request payload
// and default widths. The payload struct uses the default widths below.
package ar_channel_arbiter_pkg;

  localparam int AR_ADDR_W    = 64;
  localparam int AR_LEN_W     = 8;
  localparam int AR_ID_W      = 4;
  localparam int AR_MAX_OUTST = 8;
  localparam int OUTST_W      = $clog2(AR_MAX_OUTST) + 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD_D = 2'd1,
    ARB_HOLD_P = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [AR_LEN_W-1:0]  len;
    logic [AR_ADDR_W-1:0] addr;
    logic [AR_ID_W-1:0]   id;
  } ar_req_t;

endpackage

// File: rtl/ar_channel_arbiter_outst_counter.sv
// Outstanding-burst counter: +1 on inc, -1 on dec, net zero when both fire,
// held at 0 on a stray decrement and at MAX on a stray increment.
module outst_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && (r_count != W'(MAX))) begin
      r_count <= r_count + W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ar_channel_arbiter.sv
// Two-requester AXI AR arbiter (demand priority, starvation-bounded prefetch)
// with registered grant and per-source outstanding tracking. Optional AR_ARB_STATS_EN.
module ar_channel_arbiter
  import ar_channel_arbiter_pkg::*;
#(
  parameter int ADDR_BITS       = AR_ADDR_W,
  parameter int BURST_LEN_WIDTH = AR_LEN_W,
  parameter int TID_WIDTH       = AR_ID_W,
  parameter int MAX_OUTST       = AR_MAX_OUTST,
  parameter int STARVE_MAX      = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       d_ar_valid,
  output logic                       d_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0] d_ar_len,
  input  logic [ADDR_BITS-1:0]       d_ar_addr,
  input  logic [TID_WIDTH-1:0]       d_ar_id,
  input  logic                       p_ar_valid,
  output logic                       p_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
  input  logic [ADDR_BITS-1:0]       p_ar_addr,
  input  logic [TID_WIDTH-1:0]       p_ar_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  input  logic                       m_r_valid,
  input  logic                       m_r_ready,
  input  logic                       m_r_last,
  input  logic [TID_WIDTH-1:0]       m_r_id,
  input  logic [TID_WIDTH-1:0]       pf_id,
  input  logic                       pf_flush,
  output logic                       pf_idle,
  output logic [$clog2(MAX_OUTST):0] d_outst,
  output logic [$clog2(MAX_OUTST):0] p_outst
`ifdef AR_ARB_STATS_EN
  ,
  output logic [31:0]                stat_d_grants,
  output logic [31:0]                stat_p_grants,
  output logic [31:0]                stat_stall
`endif
);

  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  ar_req_t       r_req;
  logic [SW-1:0] r_starve;

  logic          w_adv;
  logic          w_d_elig;
  logic          w_p_elig;
  logic          w_d_pick;
  logic          w_p_pick;
  logic          w_m_hs;
  logic          w_r_last;
  logic          w_d_inc;
  logic          w_p_inc;
  logic          w_d_dec;
  logic          w_p_dec;
  logic [CW-1:0] w_d_outst;
  logic [CW-1:0] w_p_outst;
  logic [CW:0]   w_d_infl;
  logic [CW:0]   w_p_infl;

  // A request sitting in HOLD_x is not yet counted, so it is added here to keep
  // the in-flight total (and thus the counter) from ever exceeding MAX_OUTST.
  assign w_d_infl = {1'b0, w_d_outst} + {{CW{1'b0}}, (r_state == ARB_HOLD_D)};
  assign w_p_infl = {1'b0, w_p_outst} + {{CW{1'b0}}, (r_state == ARB_HOLD_P)};

  assign w_adv    = (r_state == ARB_IDLE) | m_ar_ready;
  assign w_d_elig = d_ar_valid & (w_d_infl < (CW+1)'(MAX_OUTST));
  assign w_p_elig = p_ar_valid & (w_p_infl < (CW+1)'(MAX_OUTST)) & ~pf_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_d_pick    = 1'b0;
    w_p_pick    = 1'b0;
    if (w_adv) begin
      if (w_d_elig && !(w_p_elig && (r_starve == SW'(STARVE_MAX)))) begin
        w_d_pick    = 1'b1;
        w_state_nxt = ARB_HOLD_D;
      end else if (w_p_elig) begin
        w_p_pick    = 1'b1;
        w_state_nxt = ARB_HOLD_P;
      end else begin
        w_state_nxt = ARB_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_req <= '0;
    end else if (w_d_pick) begin
      r_req.len  <= d_ar_len;
      r_req.addr <= d_ar_addr;
      r_req.id   <= d_ar_id;
    end else if (w_p_pick) begin
      r_req.len  <= p_ar_len;
      r_req.addr <= p_ar_addr;
      r_req.id   <= p_ar_id;
    end
  end

  // Starvation only accrues while prefetch could actually have been served.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_starve <= '0;
    end else if (w_p_pick || !w_p_elig) begin
      r_starve <= '0;
    end else if (w_d_pick && (r_starve != SW'(STARVE_MAX))) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign w_m_hs   = m_ar_valid & m_ar_ready;
  assign w_d_inc  = w_m_hs & (r_state == ARB_HOLD_D);
  assign w_p_inc  = w_m_hs & (r_state == ARB_HOLD_P);
  assign w_r_last = m_r_valid & m_r_ready & m_r_last;
  assign w_p_dec  = w_r_last & (m_r_id == pf_id);
  assign w_d_dec  = w_r_last & (m_r_id != pf_id);

  outst_counter #(.MAX(MAX_OUTST), .W(CW)) u_d_outst (
    .clk     (clk),
    .resetN  (resetN),
    .i_inc   (w_d_inc),
    .i_dec   (w_d_dec),
    .o_count (w_d_outst)
  );

  outst_counter #(.MAX(MAX_OUTST), .W(CW)) u_p_outst (
    .clk     (clk),
    .resetN  (resetN),
    .i_inc   (w_p_inc),
    .i_dec   (w_p_dec),
    .o_count (w_p_outst)
  );

  assign d_ar_ready = w_d_pick;
  assign p_ar_ready = w_p_pick;
  assign m_ar_valid = (r_state != ARB_IDLE);
  assign m_ar_len   = r_req.len;
  assign m_ar_addr  = r_req.addr;
  assign m_ar_id    = r_req.id;
  assign d_outst    = w_d_outst;
  assign p_outst    = w_p_outst;
  assign pf_idle    = (r_state != ARB_HOLD_P) & (w_p_outst == '0);

`ifdef AR_ARB_STATS_EN
  logic [31:0] r_stat_d;
  logic [31:0] r_stat_p;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_stat_d     <= '0;
      r_stat_p     <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_d_pick) r_stat_d <= r_stat_d + 32'd1;
      if (w_p_pick) r_stat_p <= r_stat_p + 32'd1;
      if (m_ar_valid && !m_ar_ready) r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_d_grants = r_stat_d;
  assign stat_p_grants = r_stat_p;
  assign stat_stall    = r_stat_stall;
`endif

endmodule

// File: tb/tb_ar_channel_arbiter.sv
// Scoreboard bench for ar_channel_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbitration rules.
module tb_ar_channel_arbiter;

  localparam int AW   = 64;
  localparam int LW   = 8;
  localparam int IW   = 4;
  localparam int MAXO = 8;
  localparam int SMAX = 4;
  localparam int CW   = 4;
  localparam byte GD  = 8'h44;
  localparam byte GP  = 8'h50;

  logic          clk = 1'b0;
  logic          resetN = 1'b1;
  logic          d_ar_valid = 1'b0, p_ar_valid = 1'b0, m_ar_ready = 1'b0;
  logic [LW-1:0] d_ar_len = '0, p_ar_len = '0;
  logic [AW-1:0] d_ar_addr = '0, p_ar_addr = '0;
  logic [IW-1:0] d_ar_id = '0, p_ar_id = '0;
  logic          m_r_valid = 1'b0, m_r_ready = 1'b0, m_r_last = 1'b0;
  logic [IW-1:0] m_r_id = '0;
  logic [IW-1:0] pf_id = 4'hA;
  logic          pf_flush = 1'b0;
  logic          d_ar_ready, p_ar_ready, m_ar_valid, pf_idle;
  logic [LW-1:0] m_ar_len;
  logic [AW-1:0] m_ar_addr;
  logic [IW-1:0] m_ar_id;
  logic [CW-1:0] d_outst, p_outst;

  always #5 clk = ~clk;

  ar_channel_arbiter #(
    .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
    .MAX_OUTST(MAXO), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .resetN(resetN),
    .d_ar_valid(d_ar_valid), .d_ar_ready(d_ar_ready),
    .d_ar_len(d_ar_len), .d_ar_addr(d_ar_addr), .d_ar_id(d_ar_id),
    .p_ar_valid(p_ar_valid), .p_ar_ready(p_ar_ready),
    .p_ar_len(p_ar_len), .p_ar_addr(p_ar_addr), .p_ar_id(p_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_ar_len(m_ar_len), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last), .m_r_id(m_r_id),
    .pf_id(pf_id), .pf_flush(pf_flush), .pf_idle(pf_idle),
    .d_outst(d_outst), .p_outst(p_outst)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [IW-1:0] id;
  } exp_t;

  exp_t q[$];
  byte  glog[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: which source (0 none, 1 demand, 2 prefetch) the downstream
  // port is presenting, bursts issued-but-unreturned, and the starvation tally.
  int   md_hold, md_d, md_p, md_starve;
  bit   last_gd, last_gp;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [IW-1:0] rand_did();
    logic [IW-1:0] v;
    v = IW'($urandom);
    if (v == pf_id) v = v ^ 4'h1;
    return v;
  endfunction

  task automatic new_d();
    d_ar_addr = {$urandom, $urandom};
    d_ar_len  = LW'($urandom);
    d_ar_id   = rand_did();
  endtask

  task automatic new_p();
    p_ar_addr = {$urandom, $urandom};
    p_ar_len  = LW'($urandom);
    p_ar_id   = pf_id;
  endtask

  task automatic set_r(input bit v, input logic [IW-1:0] id);
    m_r_valid = v;
    m_r_ready = v;
    m_r_last  = v;
    m_r_id    = id;
  endtask

  // Called with inputs already applied (posedge+2); checks, advances the model,
  // and returns at the next posedge+2.
  task automatic cyc();
    int   infl_d, infl_p, nd, np;
    bit   adv, pe, de, gd, gp, hs, rl;
    exp_t e;
    #1;
    adv    = (md_hold == 0) || m_ar_ready;
    infl_d = md_d + ((md_hold == 1) ? 1 : 0);
    infl_p = md_p + ((md_hold == 2) ? 1 : 0);
    pe     = p_ar_valid && (infl_p < MAXO) && !pf_flush;
    de     = d_ar_valid && (infl_d < MAXO);
    gd     = adv && de && !(pe && (md_starve == SMAX));
    gp     = adv && !gd && pe;
    chk("d_ar_ready", 64'(d_ar_ready), 64'(gd));
    chk("p_ar_ready", 64'(p_ar_ready), 64'(gp));
    chk("m_ar_valid", 64'(m_ar_valid), 64'(md_hold != 0));
    chk("d_outst", 64'(d_outst), 64'(md_d));
    chk("p_outst", 64'(p_outst), 64'(md_p));
    chk("pf_idle", 64'(pf_idle), 64'((md_hold != 2) && (md_p == 0)));
    if (gd) begin
      e.addr = d_ar_addr; e.len = d_ar_len; e.id = d_ar_id;
      q.push_back(e);
      glog.push_back(GD);
    end else if (gp) begin
      e.addr = p_ar_addr; e.len = p_ar_len; e.id = p_ar_id;
      q.push_back(e);
      glog.push_back(GP);
    end
    hs = (md_hold != 0) && m_ar_ready;
    rl = m_r_valid && m_r_ready && m_r_last;
    nd = md_d + ((hs && md_hold == 1) ? 1 : 0) - ((rl && m_r_id != pf_id) ? 1 : 0);
    np = md_p + ((hs && md_hold == 2) ? 1 : 0) - ((rl && m_r_id == pf_id) ? 1 : 0);
    md_d = (nd < 0) ? 0 : nd;
    md_p = (np < 0) ? 0 : np;
    if (gp || !pe) md_starve = 0;
    else if (gd && md_starve < SMAX) md_starve++;
    if (gd) md_hold = 1;
    else if (gp) md_hold = 2;
    else if (adv) md_hold = 0;
    last_gd = gd;
    last_gp = gp;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    d_ar_valid = 0; p_ar_valid = 0; m_ar_ready = 0; pf_flush = 0;
    set_r(0, '0);
    resetN = 0;
    #1;
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_m_ar_addr", m_ar_addr, 64'd0);
    chk("rst_d_outst", 64'(d_outst), 64'd0);
    chk("rst_p_outst", 64'(p_outst), 64'd0);
    chk("rst_pf_idle", 64'(pf_idle), 64'd1);
    chk("rst_d_ready", 64'(d_ar_ready), 64'd0);
    chk("rst_p_ready", 64'(p_ar_ready), 64'd0);
    md_hold = 0; md_d = 0; md_p = 0; md_starve = 0;
    q.delete();
    glog.delete();
    repeat (2) @(posedge clk);
    #2;
    resetN = 1;
  endtask

  // Monitor: every presented AR must match the oldest granted request, and stay
  // unchanged until it is accepted.
  always @(negedge clk) begin
    if (resetN && m_ar_valid) begin
      if (q.size() == 0) begin
        chk("ar_unexpected", 64'd1, 64'd0);
      end else begin
        chk("m_ar_addr", m_ar_addr, q[0].addr);
        chk("m_ar_len", 64'(m_ar_len), 64'(q[0].len));
        chk("m_ar_id", 64'(m_ar_id), 64'(q[0].id));
        if (m_ar_ready) q.delete(0);
      end
    end
  end

  initial begin
    string pat;
    pat = "DDDDPDDDDP";
    #2;
    do_reset();

    // Both requesters always valid: starvation limit forces every fifth grant to prefetch.
    d_ar_valid = 1; p_ar_valid = 1; m_ar_ready = 1;
    new_d(); new_p();
    repeat (10) begin
      cyc();
      if (last_gd) new_d();
      if (last_gp) new_p();
    end
    chk("starve_grant_count", 64'(glog.size()), 64'd10);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      chk("starve_seq", 64'(glog[i]), 64'(pat[i]));
    d_ar_valid = 0; p_ar_valid = 0;
    repeat (2) cyc();

    // Downstream stall on a demand request, then back-to-back accept on release.
    do_reset();
    d_ar_valid = 1; m_ar_ready = 0;
    new_d();
    cyc();
    new_d();
    repeat (3) cyc();
    chk("stall_grants", 64'(glog.size()), 64'd1);
    m_ar_ready = 1;
    cyc();
    chk("b2b_grant", 64'(glog.size()), 64'd2);
    d_ar_valid = 0;
    repeat (2) cyc();

    // Fill prefetch outstanding limit, then free one slot with an R last.
    do_reset();
    p_ar_valid = 1; m_ar_ready = 1;
    new_p();
    repeat (12) begin
      cyc();
      if (last_gp) new_p();
    end
    chk("p_outst_full", 64'(p_outst), 64'd8);
    chk("p_ready_full", 64'(p_ar_ready), 64'd0);
    chk("p_full_grants", 64'(glog.size()), 64'd8);
    set_r(1, pf_id);
    cyc();
    set_r(0, '0);
    #1;
    chk("p_outst_after_r", 64'(p_outst), 64'd7);
    chk("p_ready_after_r", 64'(p_ar_ready), 64'd1);
    cyc();
    p_ar_valid = 0;
    repeat (2) cyc();

    // Flush while a prefetch AR is held: it completes, nothing further is granted.
    do_reset();
    p_ar_valid = 1; m_ar_ready = 0;
    new_p();
    cyc();
    new_p();
    pf_flush = 1; m_ar_ready = 1;
    repeat (4) cyc();
    chk("flush_no_grant", 64'(glog.size()), 64'd1);
    chk("flush_p_outst", 64'(p_outst), 64'd1);
    chk("flush_busy", 64'(pf_idle), 64'd0);
    set_r(1, pf_id);
    cyc();
    set_r(0, '0);
    #1;
    chk("flush_idle", 64'(pf_idle), 64'd1);
    cyc();
    pf_flush = 0; p_ar_valid = 0;
    cyc();

    // Prefetch AR handshake and prefetch R last in the same cycle cancel out.
    do_reset();
    p_ar_valid = 1; m_ar_ready = 1;
    new_p();
    cyc(); new_p();
    cyc(); new_p();
    set_r(1, pf_id);
    cyc();
    set_r(0, '0);
    p_ar_valid = 0;
    #1;
    chk("same_cycle_p_outst", 64'(p_outst), 64'd1);
    m_ar_ready = 0;
    repeat (2) cyc();

    // Reset while stalled in HOLD_P with one prefetch outstanding.
    chk("pre_rst_hold", 64'(m_ar_valid), 64'd1);
    do_reset();
    chk("post_rst_valid", 64'(m_ar_valid), 64'd0);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if (!d_ar_valid || last_gd) begin
        d_ar_valid = ($urandom % 3) != 0;
        new_d();
      end
      if (!p_ar_valid || last_gp) begin
        p_ar_valid = ($urandom % 3) != 0;
        new_p();
      end
      m_ar_ready = ($urandom % 4) != 0;
      m_r_valid  = ($urandom % 3) == 0;
      m_r_ready  = ($urandom % 4) != 0;
      m_r_last   = ($urandom % 2) == 0;
      m_r_id     = (($urandom % 2) == 0) ? pf_id : rand_did();
      pf_flush   = ($urandom % 16) == 0;
      cyc();
    end
    d_ar_valid = 0; p_ar_valid = 0; m_ar_ready = 1; pf_flush = 0;
    set_r(0, '0);
    last_gd = 0; last_gp = 0;
    repeat (3) cyc();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
